// File: rtl/serial_operand_reg_pkg.sv
// Shared definitions for the fp32adder serial operand register: state encodings and default word width.
package serial_operand_reg_pkg;

  localparam int FP32_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FULL   = 2'd2,
    ST_UNLOAD = 2'd3
  } state_e;

endpackage

// File: rtl/serial_operand_reg_bit_counter.sv
// serial_bit_counter: modulo-(TERM+1) bit counter. It counts accepted serial bits and flags the
// terminal increment (wrap). It is shared by the load path and the optional unload path.
module serial_bit_counter #(
  parameter int CNT_W = 5,
  parameter int TERM  = 31
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic inc,
  output logic wrap
);

  localparam logic [CNT_W-1:0] TERM_V = CNT_W'(TERM);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             at_term;

  always_comb begin
    at_term = (count_q == TERM_V);
    wrap    = inc & at_term;
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = at_term ? '0 : count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/serial_operand_reg.sv
// serial_operand_reg: assembles WIDTH serial bits into an operand word and offers it with valid/ready.
// Optional parallel-load/serial-unload path is built when SERIAL_OUT_EN is defined.
module serial_operand_reg
  import serial_operand_reg_pkg::*;
#(
  parameter int WIDTH     = FP32_W,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             sin_valid,
  input  logic             sin_bit,
  output logic             sin_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun
`ifdef SERIAL_OUT_EN
  ,
  input  logic             par_load,
  input  logic [WIDTH-1:0] par_data,
  output logic             sout_bit,
  output logic             sout_valid,
  input  logic             sout_ready
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  state_e           state_q;
  state_e           state_d;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;
  logic             overrun_q;
  logic             overrun_d;

  logic             accept;
  logic             cnt_inc;
  logic             cnt_wrap;
  logic [WIDTH-1:0] sreg_shift_in;

`ifdef SERIAL_OUT_EN
  logic             par_take;
  logic             shift_out;
  logic [WIDTH-1:0] sreg_shift_out;
  logic             sreg_head;
`endif

  // Shift direction is fixed at elaboration; the first bit ends up at the MSB or the LSB.
  if (MSB_FIRST != 0) begin : g_msb_first
    assign sreg_shift_in = {sreg_q[WIDTH-2:0], sin_bit};
`ifdef SERIAL_OUT_EN
    assign sreg_shift_out = {sreg_q[WIDTH-2:0], 1'b0};
    assign sreg_head      = sreg_q[WIDTH-1];
`endif
  end else begin : g_lsb_first
    assign sreg_shift_in = {sin_bit, sreg_q[WIDTH-1:1]};
`ifdef SERIAL_OUT_EN
    assign sreg_shift_out = {1'b0, sreg_q[WIDTH-1:1]};
    assign sreg_head      = sreg_q[0];
`endif
  end

  always_comb begin
    out_valid = (state_q == ST_FULL);
    busy      = (state_q == ST_SHIFT);
    out_data  = sreg_q;
    overrun   = overrun_q;
`ifdef SERIAL_OUT_EN
    // A parallel load in IDLE wins over a serial bit offered in the same cycle.
    par_take   = par_load & (state_q == ST_IDLE);
    sin_ready  = ((state_q == ST_IDLE) & ~par_load) | (state_q == ST_SHIFT) |
                 ((state_q == ST_FULL) & out_ready);
    sout_valid = (state_q == ST_UNLOAD);
    sout_bit   = sout_valid & sreg_head;
    shift_out  = sout_valid & sout_ready;
`else
    sin_ready  = (state_q != ST_FULL) | out_ready;
`endif
    accept  = sin_valid & sin_ready;
`ifdef SERIAL_OUT_EN
    cnt_inc = accept | shift_out;
`else
    cnt_inc = accept;
`endif
  end

  serial_bit_counter #(
    .CNT_W (CNT_W),
    .TERM  (WIDTH - 1)
  ) u_bit_counter (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (clr),
    .inc     (cnt_inc),
    .wrap    (cnt_wrap)
  );

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    overrun_d = overrun_q | (sin_valid & ~sin_ready);
    if (accept) begin
      sreg_d = sreg_shift_in;
    end
    case (state_q)
      ST_IDLE, ST_SHIFT: begin
        if (accept) begin
          state_d = cnt_wrap ? ST_FULL : ST_SHIFT;
        end
`ifdef SERIAL_OUT_EN
        if (par_take) begin
          sreg_d  = par_data;
          state_d = ST_UNLOAD;
        end
`endif
      end
      ST_FULL: begin
        // Retiring with a bit on the same cycle starts the next word without a bubble.
        if (out_ready) begin
          state_d = sin_valid ? ST_SHIFT : ST_IDLE;
        end
      end
`ifdef SERIAL_OUT_EN
      ST_UNLOAD: begin
        if (shift_out) begin
          sreg_d = sreg_shift_out;
          if (cnt_wrap) begin
            state_d = ST_IDLE;
          end
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (clr) begin
      state_d   = ST_IDLE;
      sreg_d    = '0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      sreg_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      overrun_q <= overrun_d;
    end
  end

endmodule
